// File: rtl/passcode_entry_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// passcode_entry_ctrl_pkg
// Shared definitions for the keypad passcode front end:
//   - code geometry (NUM_DIGITS BCD digits, PW = NUM_DIGITS*4 bits)
//   - 2-bit FSM state encoding
//   - keypad command codes (CLEAR / ENTER / SET)
//   - is_digit() helper used by the key decode
// -----------------------------------------------------------------------------
package passcode_entry_ctrl_pkg;

  localparam int NUM_DIGITS = 3;
  localparam int PW         = NUM_DIGITS * 4;

  // digit_cnt value that marks a complete code.
  localparam logic [1:0] CNT_FULL = 2'(NUM_DIGITS);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ENTRY     = 2'd1,
    ST_SET_ENTRY = 2'd2,
    ST_VERIFY    = 2'd3
  } state_t;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;
  localparam logic [3:0] KEY_SET   = 4'hC;

  // Only 0-9 may ever be shifted into a code.
  function automatic logic is_digit(input logic [3:0] key);
    return key <= 4'd9;
  endfunction

endpackage

// File: rtl/passcode_entry_ctrl_idle_timer.sv
// -----------------------------------------------------------------------------
// passcode_entry_ctrl_idle_timer
// Idle-cycle counter for the passcode FSM. Counts while 'run' is high, is
// cleared by 'clear', and flags the terminal count (TIMEOUT_CYC-1) on 'expire'.
// 'expire' is a decode of the counter; the owner registers the resulting pulse.
// Ports:
//   clk    in  clock
//   rst    in  asynchronous active-low reset
//   run    in  count enable (FSM outside IDLE)
//   clear  in  synchronous clear (key activity or state change)
//   expire out high while running and the counter sits at TIMEOUT_CYC-1
// -----------------------------------------------------------------------------
module passcode_entry_ctrl_idle_timer #(
  parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic expire
);

  localparam int unsigned CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] ctr;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctr <= '0;
    end else if (clear) begin
      ctr <= '0;
    end else if (run && (ctr != TERM)) begin
      ctr <= ctr + 1'b1;
    end
  end

  assign expire = run && (ctr == TERM);

endmodule

// File: rtl/passcode_entry_ctrl.sv
// -----------------------------------------------------------------------------
// passcode_entry_ctrl
// Keypad front end of the digital lock. Shifts BCD digits into pass_in,
// maintains pass_set through a SET sequence, and raises enb so the downstream
// 12-bit comparator evaluates pass_in against pass_set. Entries left idle for
// TIMEOUT_CYC cycles are aborted.
// Ports:
//   clk        in   clock, all state on rising edge
//   rst        in   asynchronous active-low reset
//   key_valid  in   one-cycle key strobe
//   key_code   in   0-9 digit, A CLEAR, B ENTER, C SET, D-F ignored
//   pass_in    out  entered code, first digit in the MS nibble
//   pass_set   out  stored code
//   enb        out  comparator enable, high throughout VERIFY
//   digit_cnt  out  digits captured in the current entry
//   set_mode   out  high in SET_ENTRY
//   err        out  one-cycle pulse: ENTER on an incomplete code
//   timeout    out  one-cycle pulse: idle abort
// -----------------------------------------------------------------------------
module passcode_entry_ctrl
  import passcode_entry_ctrl_pkg::*;
#(
  parameter int unsigned    TIMEOUT_CYC = 50_000_000,
  parameter logic [PW-1:0]  PASS_RESET  = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_valid,
  input  logic [3:0]    key_code,
  output logic [PW-1:0] pass_in,
  output logic [PW-1:0] pass_set,
  output logic          enb,
  output logic [1:0]    digit_cnt,
  output logic          set_mode,
  output logic          err,
  output logic          timeout
);

  state_t state;
  logic   expire;
  logic   key_digit;

  assign key_digit = is_digit(key_code);

  // Every state change is caused by either a key or an expiry, so clearing on
  // those two events also covers "cleared on state change".
  passcode_entry_ctrl_idle_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_idle_timer (
    .clk    (clk),
    .rst    (rst),
    .run    (state != ST_IDLE),
    .clear  (key_valid | expire),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      pass_in   <= '0;
      pass_set  <= PASS_RESET;
      digit_cnt <= '0;
      err       <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      err     <= 1'b0;
      timeout <= 1'b0;

      // A key on the terminal cycle wins over the timeout.
      if (key_valid) begin
        unique case (state)
          ST_IDLE: begin
            if (key_digit) begin
              state     <= ST_ENTRY;
              pass_in   <= {{(PW-4){1'b0}}, key_code};
              digit_cnt <= 2'd1;
            end else if (key_code == KEY_SET) begin
              state     <= ST_SET_ENTRY;
              pass_in   <= '0;
              digit_cnt <= '0;
            end
          end

          ST_ENTRY, ST_SET_ENTRY: begin
            if (key_digit) begin
              // Extra digits beyond a full code are dropped, not wrapped.
              if (digit_cnt < CNT_FULL) begin
                pass_in   <= {pass_in[PW-5:0], key_code};
                digit_cnt <= digit_cnt + 2'd1;
              end
            end else if (key_code == KEY_CLEAR) begin
              pass_in   <= '0;
              digit_cnt <= '0;
            end else if (key_code == KEY_ENTER) begin
              if (digit_cnt == CNT_FULL) begin
                if (state == ST_ENTRY) begin
                  state <= ST_VERIFY;
                end else begin
                  pass_set  <= pass_in;
                  pass_in   <= '0;
                  digit_cnt <= '0;
                  state     <= ST_IDLE;
                end
              end else begin
                err       <= 1'b1;
                pass_in   <= '0;
                digit_cnt <= '0;
                state     <= ST_IDLE;
              end
            end
          end

          ST_VERIFY: begin
            if (key_digit) begin
              state     <= ST_ENTRY;
              pass_in   <= {{(PW-4){1'b0}}, key_code};
              digit_cnt <= 2'd1;
            end else if (key_code == KEY_SET) begin
              state     <= ST_SET_ENTRY;
              pass_in   <= '0;
              digit_cnt <= '0;
            end else if ((key_code == KEY_CLEAR) || (key_code == KEY_ENTER)) begin
              state     <= ST_IDLE;
              pass_in   <= '0;
              digit_cnt <= '0;
            end
          end

          default: state <= ST_IDLE;
        endcase
      end else if (expire) begin
        timeout   <= 1'b1;
        pass_in   <= '0;
        digit_cnt <= '0;
        state     <= ST_IDLE;
      end
    end
  end

  assign set_mode = (state == ST_SET_ENTRY);
  assign enb      = (state == ST_VERIFY);

endmodule

// File: tb/tb_passcode_entry_ctrl.sv
// -----------------------------------------------------------------------------
// tb_passcode_entry_ctrl
// Self-checking bench for passcode_entry_ctrl with TIMEOUT_CYC = 16.
// A table of per-cycle vectors covers the entry/set/verify flows; hand-written
// sequences cover the idle timeout, key-vs-timeout priority and async reset.
// -----------------------------------------------------------------------------
module tb_passcode_entry_ctrl;

  localparam int          TO_CYC = 16;
  localparam logic [11:0] PRST   = 12'h321;

  localparam logic [3:0] K_CLR = 4'hA;
  localparam logic [3:0] K_ENT = 4'hB;
  localparam logic [3:0] K_SET = 4'hC;
  localparam logic [3:0] K_IGN = 4'hD;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [11:0] pass_in;
  logic [11:0] pass_set;
  logic        enb;
  logic [1:0]  digit_cnt;
  logic        set_mode;
  logic        err;
  logic        timeout;

  passcode_entry_ctrl #(
    .TIMEOUT_CYC (TO_CYC),
    .PASS_RESET  (PRST)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .pass_in   (pass_in),
    .pass_set  (pass_set),
    .enb       (enb),
    .digit_cnt (digit_cnt),
    .set_mode  (set_mode),
    .err       (err),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        kv;
    logic [3:0]  kc;
    logic [11:0] pin;
    logic [11:0] pset;
    logic        enb;
    logic [1:0]  cnt;
    logic        smode;
    logic        err;
    logic        to;
  } vec_t;

  int   n_checks = 0;
  int   n_errors = 0;
  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t mk(logic kv, logic [3:0] kc, logic [11:0] pin,
                              logic [11:0] pset, logic e, logic [1:0] cnt,
                              logic sm, logic er, logic to);
    vec_t v;
    v.kv = kv; v.kc = kc; v.pin = pin; v.pset = pset; v.enb = e;
    v.cnt = cnt; v.smode = sm; v.err = er; v.to = to;
    return v;
  endfunction

  function automatic logic [29:0] pack_exp(vec_t v);
    return {v.pin, v.pset, v.enb, v.cnt, v.smode, v.err, v.to};
  endfunction

  function automatic logic [29:0] pack_obs();
    return {pass_in, pass_set, enb, digit_cnt, set_mode, err, timeout};
  endfunction

  task automatic check(input string name, input logic [29:0] got, input logic [29:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got pin=%h pset=%h enb=%b cnt=%0d sm=%b err=%b to=%b, want pin=%h pset=%h enb=%b cnt=%0d sm=%b err=%b to=%b",
               name, got[29:18], got[17:6], got[5], got[4:3], got[2], got[1], got[0],
               exp[29:18], exp[17:6], exp[5], exp[4:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic step(input vec_t v, input string name);
    vec_t e;
    @(negedge clk);
    key_valid = v.kv;
    key_code  = v.kc;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check(name, pack_obs(), pack_exp(e));
  endtask

  // n idle cycles, all expected to hold the given outputs with no pulses.
  task automatic idle_hold(input int n, input logic [11:0] pin, input logic [11:0] pset,
                           input logic [1:0] cnt, input string name);
    for (int i = 0; i < n; i++)
      step(mk(1'b0, 4'h3, pin, pset, 1'b0, cnt, 1'b0, 1'b0, 1'b0), name);
  endtask

  initial begin
    rst       = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'h0;

    // ---- Stimulus table: {kv, kc} -> outputs after that edge ----
    // 1: 1,2,3,ENTER -> VERIFY with 123
    tbl.push_back(mk(1, 4'h1, 12'h001, PRST, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 4'h2, 12'h012, PRST, 0, 2, 0, 0, 0));
    tbl.push_back(mk(1, 4'h3, 12'h123, PRST, 0, 3, 0, 0, 0));
    tbl.push_back(mk(1, K_ENT, 12'h123, PRST, 1, 3, 0, 0, 0));
    tbl.push_back(mk(0, K_ENT, 12'h123, PRST, 1, 3, 0, 0, 0));   // strobe low: no effect
    // 2: SET,4,5,6,ENTER -> pass_set 456 (SET also leaves VERIFY)
    tbl.push_back(mk(1, K_SET, 12'h000, PRST, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 4'h4, 12'h004, PRST, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 4'h5, 12'h045, PRST, 0, 2, 1, 0, 0));
    tbl.push_back(mk(1, 4'h6, 12'h456, PRST, 0, 3, 1, 0, 0));
    tbl.push_back(mk(1, K_ENT, 12'h000, 12'h456, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, K_ENT, 12'h000, 12'h456, 0, 0, 0, 0, 0)); // ENTER in IDLE: no err
    // 3: 7,8,ENTER -> err
    tbl.push_back(mk(1, 4'h7, 12'h007, 12'h456, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 4'h8, 12'h078, 12'h456, 0, 2, 0, 0, 0));
    tbl.push_back(mk(1, K_ENT, 12'h000, 12'h456, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 4'h0, 12'h000, 12'h456, 0, 0, 0, 0, 0));
    // 4: 1,2,3,4 (4th dropped), D and SET ignored, ENTER -> VERIFY, 9 -> ENTRY 009
    tbl.push_back(mk(1, 4'h1, 12'h001, 12'h456, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 4'h2, 12'h012, 12'h456, 0, 2, 0, 0, 0));
    tbl.push_back(mk(1, 4'h3, 12'h123, 12'h456, 0, 3, 0, 0, 0));
    tbl.push_back(mk(1, 4'h4, 12'h123, 12'h456, 0, 3, 0, 0, 0));
    tbl.push_back(mk(1, K_IGN, 12'h123, 12'h456, 0, 3, 0, 0, 0));
    tbl.push_back(mk(1, K_SET, 12'h123, 12'h456, 0, 3, 0, 0, 0));
    tbl.push_back(mk(1, K_ENT, 12'h123, 12'h456, 1, 3, 0, 0, 0));
    tbl.push_back(mk(1, 4'h9, 12'h009, 12'h456, 0, 1, 0, 0, 0));
    // CLEAR stays in ENTRY, then a short entry errors out
    tbl.push_back(mk(1, K_CLR, 12'h000, 12'h456, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'h5, 12'h005, 12'h456, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, K_ENT, 12'h000, 12'h456, 0, 0, 0, 1, 0));
    // short SET entry: err, pass_set untouched
    tbl.push_back(mk(1, K_SET, 12'h000, 12'h456, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 4'h1, 12'h001, 12'h456, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, K_ENT, 12'h000, 12'h456, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 4'h0, 12'h000, 12'h456, 0, 0, 0, 0, 0));

    // ---- Reset state ----
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", pack_obs(), pack_exp(mk(0, 0, 12'h000, PRST, 0, 0, 0, 0, 0)));
    @(negedge clk);
    rst = 1'b1;

    // ---- Table ----
    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i], $sformatf("vec%0d", i));

    // ---- Idle timeout: key 5, 15 quiet cycles, pulse on the 16th ----
    step(mk(1, 4'h5, 12'h005, 12'h456, 0, 1, 0, 0, 0), "to_key");
    idle_hold(TO_CYC - 1, 12'h005, 12'h456, 2'd1, "to_wait");
    step(mk(0, 4'h0, 12'h000, 12'h456, 0, 0, 0, 0, 1), "to_pulse");
    step(mk(0, 4'h0, 12'h000, 12'h456, 0, 0, 0, 0, 0), "to_single");
    idle_hold(TO_CYC + 2, 12'h000, 12'h456, 2'd0, "idle_no_to");

    // ---- Key on the terminal cycle beats the timeout ----
    step(mk(1, 4'h5, 12'h005, 12'h456, 0, 1, 0, 0, 0), "prio_key1");
    idle_hold(TO_CYC - 1, 12'h005, 12'h456, 2'd1, "prio_wait");
    step(mk(1, 4'h6, 12'h056, 12'h456, 0, 2, 0, 0, 0), "prio_key2");
    idle_hold(TO_CYC - 1, 12'h056, 12'h456, 2'd2, "prio_wait2");
    step(mk(0, 4'h0, 12'h000, 12'h456, 0, 0, 0, 0, 1), "prio_to");

    // ---- Timeout out of VERIFY ----
    step(mk(1, 4'h2, 12'h002, 12'h456, 0, 1, 0, 0, 0), "vto_k1");
    step(mk(1, 4'h4, 12'h024, 12'h456, 0, 2, 0, 0, 0), "vto_k2");
    step(mk(1, 4'h8, 12'h248, 12'h456, 0, 3, 0, 0, 0), "vto_k3");
    step(mk(1, K_ENT, 12'h248, 12'h456, 1, 3, 0, 0, 0), "vto_ent");
    for (int i = 0; i < TO_CYC - 1; i++)
      step(mk(0, 4'h0, 12'h248, 12'h456, 1, 3, 0, 0, 0), "vto_wait");
    step(mk(0, 4'h0, 12'h000, 12'h456, 0, 0, 0, 0, 1), "vto_pulse");

    // ---- Async reset mid-SET_ENTRY ----
    step(mk(1, K_SET, 12'h000, 12'h456, 0, 0, 1, 0, 0), "rst_set");
    step(mk(1, 4'h1, 12'h001, 12'h456, 0, 1, 1, 0, 0), "rst_k1");
    step(mk(1, 4'h2, 12'h012, 12'h456, 0, 2, 1, 0, 0), "rst_k2");
    @(negedge clk);
    key_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("rst_async", pack_obs(), pack_exp(mk(0, 0, 12'h000, PRST, 0, 0, 0, 0, 0)));
    @(posedge clk);
    #1;
    check("rst_hold", pack_obs(), pack_exp(mk(0, 0, 12'h000, PRST, 0, 0, 0, 0, 0)));
    @(negedge clk);
    rst = 1'b1;
    step(mk(1, 4'h7, 12'h007, PRST, 0, 1, 0, 0, 0), "post_rst");

    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
